oclib_uart_rx: RTL and testbench

- UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. Same framing as the team's UART transmitter.
- Oversamples the asynchronous `rx` pin with a free-running-per-frame baud counter and samples each bit at mid-bit.
- Received bytes are buffered in an internal FIFO with a valid/ready output.
- Sits at the chip-pin end of the debug/console path, paired with the transmitter.

---
 rtl/oclib_uart_pkg.sv | 25 ++
 rtl/oclib_uart_rx_if.sv | 27 ++
 rtl/oclib_fifo.sv | 60 ++++++
 rtl/oclib_uart_rx.sv | 151 +++++++++++++++
 tb/tb_oclib_uart_rx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oclib_uart_pkg.sv
// Shared UART definitions for the receiver. The transmitter can import the
// same package later.
//   rx_state_e    : receiver FSM states
//   UartDataBits  : data bits per frame
//   mid_bit_count : counter value at which the start bit is sampled at mid-bit
package oclib_uart_pkg;

  localparam int UartDataBits = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } rx_state_e;

  // Counter value half a bit after the start edge. The start edge is already
  // aligned to a bit boundary, so stopping here places every later full-bit
  // sample near the middle of its bit.
  function automatic int mid_bit_count(input int baud_cycles);
    return baud_cycles / 2 - 1;
  endfunction

endpackage

// File: rtl/oclib_uart_rx_if.sv
// Receive-side byte stream of the UART receiver.
//   rxData     : byte at the FIFO head
//   rxValid    : rxData is valid
//   rxReady    : consumer accepts the byte when rxValid && rxReady
//   frameError : one-cycle pulse, stop bit was low and the byte was discarded
//   overflow   : one-cycle pulse, good byte dropped because the FIFO was full
// The master modport is the receiver; the slave modport is the consumer.
interface oclib_uart_rx_if;
  import oclib_uart_pkg::*;

  logic [UartDataBits-1:0] rxData;
  logic                    rxValid;
  logic                    rxReady;
  logic                    frameError;
  logic                    overflow;

  modport master (
    output rxData, rxValid, frameError, overflow,
    input  rxReady
  );

  modport slave (
    input  rxData, rxValid, frameError, overflow,
    output rxReady
  );

endinterface

// File: rtl/oclib_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i       : clock
//   rst_i       : asynchronous reset, active high
//   in_*        : write side, valid/ready handshake
//   out_*       : read side, valid/ready handshake; out_data_o reads 0 when empty
// When the FIFO is full, a write is still accepted in the same cycle as a read.
module oclib_fifo #(
  parameter int Width = 8,
  parameter int Depth = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  assign out_valid_o = (count_q != '0);
  assign in_ready_o  = (count_q != CntFull) || out_ready_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: the storage array has no reset; its contents are only visible through
  // out_data_o once count_q says the entry was written, so resetting it would
  // only cost flops.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/oclib_uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line. The asynchronous rx pin is
// synchronized, the start bit is qualified at mid-bit, data and stop bits are
// sampled at mid-bit, and good bytes are buffered in a FIFO.
//   clock : sole clock
//   reset : asynchronous reset, active low
//   rx    : serial input, asynchronous to clock
//   rx_if : received byte stream plus frameError / overflow pulses (master)
module oclib_uart_rx
  import oclib_uart_pkg::*;
#(
  parameter int ClockHz    = 100_000_000,
  parameter int Baud       = 115_200,
  parameter int BaudCycles = ClockHz / Baud,
  parameter int FifoDepth  = 32,
  parameter int SyncCycles = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rx,
  oclib_uart_rx_if.master rx_if
);

  if (BaudCycles < 4) begin : g_bad_baud
    $error("oclib_uart_rx: BaudCycles must be >= 4");
  end
  if (SyncCycles < 2) begin : g_bad_sync
    $error("oclib_uart_rx: SyncCycles must be >= 2");
  end

  localparam int CntW    = $clog2(BaudCycles);
  localparam int BitCntW = $clog2(UartDataBits);
  localparam logic [CntW-1:0]    CntLast    = CntW'(BaudCycles - 1);
  localparam logic [CntW-1:0]    CntMid     = CntW'(mid_bit_count(BaudCycles));
  localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(UartDataBits - 1);

  logic [SyncCycles-1:0]   sync_q;
  logic                    rx_s, rx_prev_q;
  rx_state_e               state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [UartDataBits-1:0] shift_q, shift_d;
  logic                    push_q, push_d;
  logic                    frame_err_q, frame_err_d;
  logic                    fifo_in_ready;

  assign rx_s = sync_q[SyncCycles-1];

  // NOTE: every variable gets a default at the top of the block so that paths
  // which do not assign it cannot infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          // A line that is high again by mid-bit was a glitch, not a start bit.
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d   = {rx_s, shift_q[UartDataBits-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntLast) state_d = StStop;
        end
      end
      StStop: begin
        // Leaving at mid-stop-bit lets the next start edge follow directly.
        if (cnt_q == CntLast) begin
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break must go high before a new start can be detected.
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The baud counter restarts on every state change so each state times
    // itself from its own entry.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CntLast) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Synchronizer and edge flop reset high so release never looks like a
      // start edge.
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SyncCycles-2:0], rx};
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  // shift_q is untouched in the cycle after the stop sample, so it can feed
  // the FIFO directly while push_q is high.
  oclib_fifo #(
    .Width (UartDataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (~reset),
    .in_data_i   (shift_q),
    .in_valid_i  (push_q),
    .in_ready_o  (fifo_in_ready),
    .out_data_o  (rx_if.rxData),
    .out_valid_o (rx_if.rxValid),
    .out_ready_i (rx_if.rxReady)
  );

  // Overflow is decided in the push cycle, so a same-cycle pop frees the slot.
  assign rx_if.overflow   = push_q & ~fifo_in_ready;
  assign rx_if.frameError = frame_err_q;

endmodule

// File: tb/tb_oclib_uart_rx.sv
// Self-checking bench for oclib_uart_rx at 10 clocks per bit, FIFO depth 4.
// Frames are driven bit by bit; a negedge monitor collects accepted bytes and
// error pulses, and expected results come from frame-level rules.
module tb_oclib_uart_rx;
  import oclib_uart_pkg::*;

  localparam int ClockHz = 1_000_000;
  localparam int Baud    = 100_000;
  localparam int BC      = ClockHz / Baud;
  localparam int Depth   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic ready = 1'b1;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  oclib_uart_rx_if u_if ();
  assign u_if.rxReady = ready;

  oclib_uart_rx #(
    .ClockHz    (ClockHz),
    .Baud       (Baud),
    .FifoDepth  (Depth),
    .SyncCycles (2)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .rx    (rx),
    .rx_if (u_if)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          cyc   = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  int          first_valid_cyc = -1;
  logic [7:0]  got_q[$];
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]  prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, where inputs and outputs are settled for the
  // coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(u_if.rxValid), 32'd1);
        check("hold_data", 32'(u_if.rxData), 32'(prev_d));
      end
      if (u_if.rxValid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (u_if.rxValid && u_if.rxReady) got_q.push_back(u_if.rxData);
      if (u_if.frameError) fe_cnt++;
      if (u_if.overflow)   ov_cnt++;
      prev_v = u_if.rxValid;
      prev_r = u_if.rxReady;
      prev_d = u_if.rxData;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // All drivers change inputs 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BC);
    end
    rx = stop_bit;
    tick(BC);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp_q[$]);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         idle_after;
    logic       exp_byte;
    logic       exp_fe;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  int         exp_fe, fe0, ov0, lat;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 20, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0,  1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 20, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 20, 1'b0, 1'b1};
    vecs[5] = '{8'h42, 1'b1, 0,  1'b1, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 25, 1'b1, 1'b0};

    // Reset values.
    tick(3);
    check("rst_valid", 32'(u_if.rxValid), 32'd0);
    check("rst_data", 32'(u_if.rxData), 32'd0);
    check("rst_frame_error", 32'(u_if.frameError), 32'd0);
    check("rst_overflow", 32'(u_if.overflow), 32'd0);
    rst_n = 1'b1;
    tick(20);
    check("idle_no_bytes", 32'(got_q.size()), 32'd0);

    // Single byte with latency bound.
    got_q.delete();
    first_valid_cyc = -1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    lat = cyc;
    send_frame(8'hA5, 1'b1);
    tick(10);
    lat = first_valid_cyc - lat;
    check("a5_latency_max", 32'(lat <= 99), 32'd1);
    check("a5_latency_min", 32'(lat >= 94), 32'd1);
    exp_q = '{8'hA5};
    check_bytes("a5", exp_q);
    check("a5_frame_error", 32'(fe_cnt - fe0), 32'd0);
    check("a5_overflow", 32'(ov_cnt - ov0), 32'd0);

    // Table: back-to-back frames, a bad stop bit, recovery.
    got_q.delete();
    exp_q.delete();
    exp_fe = 0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit);
      rx = 1'b1;
      if (vecs[i].idle_after > 0) tick(vecs[i].idle_after);
      if (vecs[i].exp_byte) exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_fe)   exp_fe++;
    end
    tick(30);
    check_bytes("table", exp_q);
    check("table_frame_error", 32'(fe_cnt - fe0), 32'(exp_fe));
    check("table_overflow", 32'(ov_cnt - ov0), 32'd0);

    // Glitch: 3-cycle low pulse, then a good frame.
    got_q.delete();
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check("glitch_no_byte", 32'(got_q.size()), 32'd0);
    check("glitch_valid", 32'(u_if.rxValid), 32'd0);
    send_frame(8'h55, 1'b1);
    tick(20);
    exp_q = '{8'h55};
    check_bytes("glitch_then_55", exp_q);
    check("glitch_frame_error", 32'(fe_cnt - fe0), 32'd0);

    // Frame error followed by a 50-cycle break.
    got_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h81, 1'b0);
    tick(50);
    rx = 1'b1;
    tick(30);
    check("break_frame_error", 32'(fe_cnt - fe0), 32'd1);
    check("break_no_byte", 32'(got_q.size()), 32'd0);
    send_frame(8'h42, 1'b1);
    tick(20);
    exp_q = '{8'h42};
    check_bytes("break_then_42", exp_q);
    check("break_frame_error_total", 32'(fe_cnt - fe0), 32'd1);

    // Overflow: five frames into a 4-deep FIFO with the consumer stalled.
    got_q.delete();
    ov0 = ov_cnt;
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    tick(5);
    check("ovf_none_after_4", 32'(ov_cnt - ov0), 32'd0);
    send_frame(8'h05, 1'b1);
    tick(10);
    check("ovf_once_on_5", 32'(ov_cnt - ov0), 32'd1);
    check("ovf_head_valid", 32'(u_if.rxValid), 32'd1);
    check("ovf_head_data", 32'(u_if.rxData), 32'h01);
    ready = 1'b1;
    tick(10);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_bytes("ovf_drain", exp_q);
    check("ovf_empty_after_drain", 32'(u_if.rxValid), 32'd0);

    // Reset in the middle of data bit 3 with a byte already buffered.
    got_q.delete();
    fe0 = fe_cnt;
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    tick(10);
    check("rstmid_preload_valid", 32'(u_if.rxValid), 32'd1);
    rx = 1'b0;
    tick(BC);
    rx = 1'b1; tick(BC);   // 0x99 bit 0
    rx = 1'b0; tick(BC);   // bit 1
    rx = 1'b0; tick(BC);   // bit 2
    rx = 1'b1; tick(4);    // part of bit 3
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(u_if.rxValid), 32'd0);
    check("rstmid_data", 32'(u_if.rxData), 32'd0);
    check("rstmid_frame_error", 32'(u_if.frameError), 32'd0);
    check("rstmid_overflow", 32'(u_if.overflow), 32'd0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    ready = 1'b1;
    tick(120);
    check("rstmid_no_byte", 32'(got_q.size()), 32'd0);
    check("rstmid_no_frame_error", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h99, 1'b1);
    tick(20);
    exp_q = '{8'h99};
    check_bytes("rstmid_then_99", exp_q);

    // Random frames with random gaps, bad stop bits and consumer stalls.
    // Reference: every good frame yields its byte in order, every bad stop
    // bit one frameError, and a consumer that drains faster than frames
    // arrive never causes an overflow.
    got_q.delete();
    exp_q.delete();
    exp_fe = 0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(b, stop);
      rx = 1'b1;
      if (gap > 0) tick(gap);
      if (stop) exp_q.push_back(b);
      else      exp_fe++;
    end
    tick(20);
    rand_ready = 1'b0;
    #2;
    ready = 1'b1;
    tick(20);
    check_bytes("rand", exp_q);
    check("rand_frame_error", 32'(fe_cnt - fe0), 32'(exp_fe));
    check("rand_overflow", 32'(ov_cnt - ov0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
